// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the two-requester register access arbiter.
package reg_arb_pkg;

    localparam int DEFAULT_WIDTH = 256;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RWAIT = 2'd2,
        RESP  = 2'd3
    } arbState_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie the requester that was not granted last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant_idx
);

    always_comb begin
        if (req[0] && req[1]) begin
            grant_idx = ~last;
        end else begin
            grant_idx = req[1];
        end
    end

endmodule

// File: rtl/reg_access_arbiter.sv
// Arbitrates two requesters onto one register port; every output is registered
// and computed from the value the FSM is about to enter.
module reg_access_arbiter
    import reg_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             rw0,
    input  logic [WIDTH-1:0] wdata0,
    output logic             gnt0,
    output logic             rvalid0,
    input  logic             req1,
    input  logic             rw1,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt1,
    output logic             rvalid1,
    output logic [WIDTH-1:0] rdata,
    output logic             RegEnable,
    output logic             RegReadWrite,
    output logic [WIDTH-1:0] RegDataIn,
    input  logic [WIDTH-1:0] RegDataOut,
    output logic             busy
);

    arbState_t state, nextState;

    logic lastGnt, curIdx, curRw;
    logic pickIdx;

    logic             nxtGnt0, nxtGnt1, nxtRvalid0, nxtRvalid1;
    logic             nxtRegEnable, nxtRegReadWrite;
    logic             nxtLastGnt, nxtCurIdx, nxtCurRw;
    logic [WIDTH-1:0] nxtRegDataIn, nxtRdata;

    rr_pick2 uPick (
        .req       ({req1, req0}),
        .last      (lastGnt),
        .grant_idx (pickIdx)
    );

    always_comb begin
        nextState       = state;
        nxtGnt0         = 1'b0;
        nxtGnt1         = 1'b0;
        nxtRvalid0      = 1'b0;
        nxtRvalid1      = 1'b0;
        nxtRegEnable    = 1'b0;
        nxtRegReadWrite = RegReadWrite;
        nxtRegDataIn    = RegDataIn;
        nxtRdata        = rdata;
        nxtLastGnt      = lastGnt;
        nxtCurIdx       = curIdx;
        nxtCurRw        = curRw;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    nextState       = GRANT;
                    nxtCurIdx       = pickIdx;
                    nxtCurRw        = pickIdx ? rw1 : rw0;
                    nxtRegEnable    = 1'b1;
                    nxtRegReadWrite = pickIdx ? rw1 : rw0;
                    nxtRegDataIn    = pickIdx ? wdata1 : wdata0;
                    nxtGnt0         = ~pickIdx;
                    nxtGnt1         = pickIdx;
                end
            end
            GRANT: begin
                nxtLastGnt = curIdx;
                if (curRw == RW_READ) begin
                    nextState = RWAIT;
                end else begin
                    nextState = IDLE;
                end
            end
            RWAIT: begin
                // The register answers one cycle after the strobe, i.e. now.
                nextState  = RESP;
                nxtRdata   = RegDataOut;
                nxtRvalid0 = ~curIdx;
                nxtRvalid1 = curIdx;
            end
            RESP: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            lastGnt      <= 1'b1;
            curIdx       <= 1'b0;
            curRw        <= RW_WRITE;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            rvalid0      <= 1'b0;
            rvalid1      <= 1'b0;
            busy         <= 1'b0;
            RegEnable    <= 1'b0;
            RegReadWrite <= RW_WRITE;
            RegDataIn    <= '0;
            rdata        <= '0;
        end else begin
            state        <= nextState;
            lastGnt      <= nxtLastGnt;
            curIdx       <= nxtCurIdx;
            curRw        <= nxtCurRw;
            gnt0         <= nxtGnt0;
            gnt1         <= nxtGnt1;
            rvalid0      <= nxtRvalid0;
            rvalid1      <= nxtRvalid1;
            busy         <= (nextState != IDLE);
            RegEnable    <= nxtRegEnable;
            RegReadWrite <= nxtRegReadWrite;
            RegDataIn    <= nxtRegDataIn;
            rdata        <= nxtRdata;
        end
    end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed and randomized checks of reg_access_arbiter against a transaction-level
// model: round-robin winner, register contents, and grant/response timing.
module tb_reg_access_arbiter;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0, rw0, req1, rw1;
    logic [W-1:0] wdata0, wdata1;
    logic         gnt0, gnt1, rvalid0, rvalid1;
    logic [W-1:0] rdata;
    logic         RegEnable, RegReadWrite;
    logic [W-1:0] RegDataIn;
    logic [W-1:0] RegDataOut = '0;
    logic         busy;

    int checks = 0;
    int passes = 0;
    logic monOn = 1'b0;

    // Register stub: writes land on the strobe edge, reads answer one cycle later.
    logic [W-1:0] regMem = '0;
    int writeCount = 0;

    // Transaction-level model state.
    logic [W-1:0] modelReg;
    int           mLast;
    logic         pend [2];
    logic         pRw [2];
    logic [W-1:0] pData [2];

    reg_access_arbiter #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0         (req0),
        .rw0          (rw0),
        .wdata0       (wdata0),
        .gnt0         (gnt0),
        .rvalid0      (rvalid0),
        .req1         (req1),
        .rw1          (rw1),
        .wdata1       (wdata1),
        .gnt1         (gnt1),
        .rvalid1      (rvalid1),
        .rdata        (rdata),
        .RegEnable    (RegEnable),
        .RegReadWrite (RegReadWrite),
        .RegDataIn    (RegDataIn),
        .RegDataOut   (RegDataOut),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (RegEnable) begin
            if (RegReadWrite) begin
                RegDataOut <= regMem;
            end else begin
                regMem     <= RegDataIn;
                writeCount <= writeCount + 1;
            end
        end
    end

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic checkData(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic checkInt(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (monOn) begin
            checkBit("gnt_onehot", gnt0 & gnt1, 1'b0);
            checkBit("rvalid_onehot", rvalid0 & rvalid1, 1'b0);
        end
    end

    function automatic logic [W-1:0] rnd();
        return {$urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic r, input logic rwv, input logic [W-1:0] d);
        if (i == 0) begin
            req0 = r; rw0 = rwv; wdata0 = d;
        end else begin
            req1 = r; rw1 = rwv; wdata1 = d;
        end
    endtask

    task automatic setReq(input int i, input logic r);
        if (i == 0) req0 = r;
        else        req1 = r;
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        mLast = 1;
    endtask

    // Waits up to 8 edges for a grant; idx = -1 if none appeared.
    task automatic waitGnt(output int idx, output int waited);
        idx = -1;
        waited = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (gnt0 || gnt1) begin
                idx = gnt1 ? 1 : 0;
                waited = k;
                break;
            end
        end
        if (idx < 0) checkBit("gnt_seen", gnt0 | gnt1, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int idx, waited, expIdx;
        int wc;
        logic [W-1:0] wd [2];

        // Reset with a request pending: reset must win.
        reset = 1'b1;
        drive(0, 1'b1, 1'b0, rnd());
        drive(1, 1'b0, 1'b0, '0);
        tick();
        tick();
        monOn = 1'b1;
        checkBit("rst_gnt0", gnt0, 1'b0);
        checkBit("rst_gnt1", gnt1, 1'b0);
        checkBit("rst_rvalid0", rvalid0, 1'b0);
        checkBit("rst_rvalid1", rvalid1, 1'b0);
        checkBit("rst_busy", busy, 1'b0);
        checkBit("rst_regen", RegEnable, 1'b0);
        checkBit("rst_regrw", RegReadWrite, 1'b0);
        checkData("rst_regdin", RegDataIn, '0);
        checkData("rst_rdata", rdata, '0);
        reset = 1'b0;
        req0 = 1'b0;
        mLast = 1;
        tick();

        // Single write by requester 0.
        drive(0, 1'b1, 1'b0, 64'hAA);
        tick();
        checkBit("wr_gnt0", gnt0, 1'b1);
        checkBit("wr_gnt1", gnt1, 1'b0);
        checkBit("wr_regen", RegEnable, 1'b1);
        checkBit("wr_regrw", RegReadWrite, 1'b0);
        checkData("wr_regdin", RegDataIn, 64'hAA);
        checkBit("wr_busy", busy, 1'b1);
        setReq(0, 1'b0);
        modelReg = 64'hAA;
        mLast = 0;
        tick();
        checkBit("wr_busy_low", busy, 1'b0);
        checkBit("wr_regen_low", RegEnable, 1'b0);
        checkBit("wr_gnt0_pulse", gnt0, 1'b0);
        checkData("wr_regdin_hold", RegDataIn, 64'hAA);

        // Single read by requester 1.
        drive(1, 1'b1, 1'b1, rnd());
        tick();
        checkBit("rd_gnt1", gnt1, 1'b1);
        checkBit("rd_regen", RegEnable, 1'b1);
        checkBit("rd_regrw", RegReadWrite, 1'b1);
        setReq(1, 1'b0);
        tick();
        checkBit("rd_wait_regen", RegEnable, 1'b0);
        checkBit("rd_wait_rvalid1", rvalid1, 1'b0);
        checkBit("rd_wait_busy", busy, 1'b1);
        checkBit("rd_wait_regrw_hold", RegReadWrite, 1'b1);
        tick();
        checkBit("rd_rvalid1", rvalid1, 1'b1);
        checkBit("rd_rvalid0", rvalid0, 1'b0);
        checkData("rd_rdata", rdata, modelReg);
        tick();
        checkBit("rd_rvalid1_pulse", rvalid1, 1'b0);
        checkBit("rd_busy_low", busy, 1'b0);
        checkData("rd_rdata_hold", rdata, modelReg);

        // Tie right after reset: requester 0 first, then requester 1.
        doReset();
        drive(0, 1'b1, 1'b0, 64'h11);
        drive(1, 1'b1, 1'b0, 64'h22);
        tick();
        checkBit("tie_gnt0", gnt0, 1'b1);
        checkBit("tie_gnt1_not", gnt1, 1'b0);
        checkData("tie_regdin0", RegDataIn, 64'h11);
        setReq(0, 1'b0);
        tick();
        checkBit("tie_idle_gap", gnt1, 1'b0);
        checkBit("tie_idle_regen", RegEnable, 1'b0);
        tick();
        checkBit("tie_gnt1", gnt1, 1'b1);
        checkData("tie_regdin1", RegDataIn, 64'h22);
        setReq(1, 1'b0);
        modelReg = 64'h22;
        mLast = 1;
        tick();
        drive(0, 1'b1, 1'b1, '0);
        tick();
        checkBit("tie_rdback_gnt0", gnt0, 1'b1);
        setReq(0, 1'b0);
        tick();
        tick();
        checkBit("tie_rdback_rvalid0", rvalid0, 1'b1);
        checkData("tie_rdback_rdata", rdata, 64'h22);
        tick();

        // Fairness: both requesters keep writing; grants must alternate.
        doReset();
        wd[0] = rnd();
        wd[1] = rnd();
        drive(0, 1'b1, 1'b0, wd[0]);
        drive(1, 1'b1, 1'b0, wd[1]);
        expIdx = 0;
        for (int g = 0; g < 8; g++) begin
            waitGnt(idx, waited);
            checkInt("fair_winner", idx, expIdx);
            checkInt("fair_gap", waited, (g == 0) ? 1 : 2);
            checkData("fair_regdin", RegDataIn, wd[expIdx]);
            modelReg = wd[expIdx];
            wd[expIdx] = rnd();
            drive(expIdx, 1'b1, 1'b0, wd[expIdx]);
            expIdx = 1 - expIdx;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        checkBit("fair_end_busy", busy, 1'b0);

        // Reset during RWAIT aborts the read.
        drive(0, 1'b1, 1'b1, '0);
        tick();
        checkBit("rstrd_gnt0", gnt0, 1'b1);
        setReq(0, 1'b0);
        tick();
        checkBit("rstrd_in_wait", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mLast = 1;
        checkBit("rstrd_idle", busy, 1'b0);
        checkBit("rstrd_regen", RegEnable, 1'b0);
        checkBit("rstrd_rvalid0", rvalid0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            tick();
            checkBit("rstrd_no_rvalid0", rvalid0, 1'b0);
            checkBit("rstrd_no_rvalid1", rvalid1, 1'b0);
        end

        // A one-cycle req1 during requester 0's RWAIT is a withdrawn request.
        wc = writeCount;
        drive(0, 1'b1, 1'b1, '0);
        tick();
        checkBit("wd_gnt0", gnt0, 1'b1);
        setReq(0, 1'b0);
        tick();
        drive(1, 1'b1, 1'b0, 64'h55);
        tick();
        setReq(1, 1'b0);
        checkBit("wd_rvalid0", rvalid0, 1'b1);
        checkData("wd_rdata", rdata, modelReg);
        for (int c = 0; c < 4; c++) begin
            tick();
            checkBit("wd_no_gnt1", gnt1, 1'b0);
            checkBit("wd_no_regen", RegEnable, 1'b0);
        end
        checkInt("wd_no_write", writeCount, wc);

        // Randomized traffic against the transaction-level model.
        doReset();
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i]  = 1'b1;
                    pRw[i]   = 1'($urandom_range(0, 1));
                    pData[i] = rnd();
                    drive(i, 1'b1, pRw[i], pData[i]);
                end
            end
            if (!pend[0] && !pend[1]) begin
                tick();
                checkBit("rand_idle_busy", busy, 1'b0);
                continue;
            end
            if (pend[0] && pend[1]) expIdx = 1 - mLast;
            else                    expIdx = pend[1] ? 1 : 0;
            waitGnt(idx, waited);
            checkInt("rand_winner", idx, expIdx);
            checkInt("rand_latency", waited, 1);
            if (idx < 0) break;
            checkBit("rand_regrw", RegReadWrite, pRw[idx]);
            setReq(idx, 1'b0);
            pend[idx] = 1'b0;
            mLast = idx;
            if (pRw[idx] == 1'b0) begin
                checkData("rand_regdin", RegDataIn, pData[idx]);
                modelReg = pData[idx];
                tick();
                checkBit("rand_wr_busy_low", busy, 1'b0);
            end else begin
                tick();
                tick();
                checkBit("rand_rvalid", (idx == 1) ? rvalid1 : rvalid0, 1'b1);
                checkBit("rand_rvalid_other", (idx == 1) ? rvalid0 : rvalid1, 1'b0);
                checkData("rand_rdata", rdata, modelReg);
                tick();
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        monOn = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
